// File: rtl/data_ram_wbuf.sv
// MEM-stage data RAM with posted write buffer, same-cycle read forwarding and loader port.
// Optional DATA_RAM_RANGE_CHECK_EN adds sticky range_err_o and blocks out-of-range accesses.
module data_ram_wbuf #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    input  logic                  ram_w_request_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic                  ld_we_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    output logic                  wbuf_full_o,
    output logic                  wbuf_empty_o,
    output logic                  overflow_o
`ifdef DATA_RAM_RANGE_CHECK_EN
    ,
    output logic                  range_err_o
`endif
);

    localparam int unsigned PTR_W  = $clog2(WBUF_DEPTH) + 1;
    localparam int unsigned SLOT_W = PTR_W - 1;
    localparam int unsigned WORDS  = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem     [WORDS];
    logic [DEPTH_LOG2-1:0] wb_idx  [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];

    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [PTR_W-1:0]      count;
    logic [SLOT_W-1:0]     head_slot;
    logic [SLOT_W-1:0]     tail_slot;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] ld_idx;

    logic addr_in_range;
    logic ld_in_range;
    logic do_drain;
    logic can_push;
    logic do_push;
    logic do_drop;
    logic ld_write;
    logic fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [SLOT_W-1:0]     slot;
    logic unused_bits;

    assign rd_idx    = ram_addr_i[DEPTH_LOG2+1:2];
    assign ld_idx    = ld_addr_i[DEPTH_LOG2+1:2];
    assign head_slot = head_ptr[SLOT_W-1:0];
    assign tail_slot = tail_ptr[SLOT_W-1:0];

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign addr_in_range = (ram_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
    assign ld_in_range   = (ld_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
    assign unused_bits   = ^{ram_addr_i[1:0], ld_addr_i[1:0],
                             head_ptr[PTR_W-1], tail_ptr[PTR_W-1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            range_err_o <= 1'b0;
        end else if ((ram_w_request_i && !addr_in_range) || (ld_we_i && !ld_in_range)) begin
            range_err_o <= 1'b1;
        end
    end
`else
    assign addr_in_range = 1'b1;
    assign ld_in_range   = 1'b1;
    assign unused_bits   = ^{ram_addr_i[1:0], ld_addr_i[1:0],
                             ram_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2],
                             ld_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2],
                             head_ptr[PTR_W-1], tail_ptr[PTR_W-1]};
`endif

    assign wbuf_full_o  = (count == PTR_W'(WBUF_DEPTH));
    assign wbuf_empty_o = (count == '0);

    // Loader owns the single array write port; any loader cycle stalls the drain.
    assign do_drain = !rst_i && !wbuf_empty_o && !ld_we_i;
    assign can_push = !wbuf_full_o || do_drain;
    assign do_push  = !rst_i && ram_w_request_i && addr_in_range && can_push;
    assign do_drop  = !rst_i && ram_w_request_i && addr_in_range && !can_push;
    assign ld_write = !rst_i && ld_we_i && ld_in_range;

    // Walk oldest to newest so the last match (newest entry) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            slot = head_slot + SLOT_W'(i);
            if ((PTR_W'(i) < count) && (wb_idx[slot] == rd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
    end

    always_comb begin
        if (rst_i || !addr_in_range) begin
            ram_data_o = '0;
        end else if (fwd_hit) begin
            ram_data_o = fwd_data;
        end else begin
            ram_data_o = mem[rd_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (do_drain) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({do_push, do_drain})
                2'b10:   count <= count + PTR_W'(1);
                2'b01:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
            if (do_drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            wb_idx[tail_slot]  <= rd_idx;
            wb_data[tail_slot] <= ram_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ld_write) begin
            mem[ld_idx] <= ld_data_i;
        end else if (do_drain) begin
            mem[wb_idx[head_slot]] <= wb_data[head_slot];
        end
    end

endmodule

// File: tb/tb_data_ram_wbuf.sv
// Directed self-checking bench for data_ram_wbuf: preload, forwarding, newest-wins,
// fill/overflow, simultaneous enqueue+drain and reset discard.
module tb_data_ram_wbuf;

    logic        clk;
    logic        rst;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        wreq;
    logic [31:0] ram_rdata;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef DATA_RAM_RANGE_CHECK_EN
    logic        range_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    data_ram_wbuf #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH_LOG2(10),
        .WBUF_DEPTH(4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ram_addr_i     (ram_addr),
        .ram_data_i     (ram_wdata),
        .ram_w_request_i(wreq),
        .ram_data_o     (ram_rdata),
        .ld_we_i        (ld_we),
        .ld_addr_i      (ld_addr),
        .ld_data_i      (ld_data),
        .wbuf_full_o    (full),
        .wbuf_empty_o   (empty),
        .overflow_o     (overflow)
`ifdef DATA_RAM_RANGE_CHECK_EN
        ,
        .range_err_o    (range_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic ld_word(input logic [31:0] addr, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ram_addr = addr;
        #1;
        check(tag, ram_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; ram_addr = '0; ram_wdata = '0; wreq = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        tick();
        tick();
        #1;
        check("rst_rdata", ram_rdata, 32'h0);
        check("rst_empty", {31'b0, empty}, 32'h1);
        check("rst_full", {31'b0, full}, 32'h0);
        check("rst_ovf", {31'b0, overflow}, 32'h0);
        rst = 1'b0;

        // Loader preload and byte-offset aliasing within the word
        ld_word(32'h10, 32'h11223344);
        rd_check("pre_10", 32'h10, 32'h11223344);
        rd_check("pre_13", 32'h13, 32'h11223344);
        check("pre_empty", {31'b0, empty}, 32'h1);

        ld_word(32'h20, 32'h0BAD0020);
        ld_word(32'h40, 32'h0BAD0040);
        for (int i = 0; i < 6; i++) ld_word(32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i));
        for (int i = 0; i < 3; i++) ld_word(32'h200 + 32'(4 * i), 32'hC0000000 + 32'(i));

        // Write then forward
        ram_addr = 32'h20; ram_wdata = 32'hDEADBEEF; wreq = 1'b1;
        #1;
        check("no_same_cycle_fwd", ram_rdata, 32'h0BAD0020);
        tick();
        wreq = 1'b0;
        #1;
        check("fwd_20", ram_rdata, 32'hDEADBEEF);
        check("fwd_not_empty", {31'b0, empty}, 32'h0);
        tick();
        #1;
        check("drain_empty", {31'b0, empty}, 32'h1);
        check("drain_20", ram_rdata, 32'hDEADBEEF);

        // Newest entry wins while drain is blocked by the loader
        ld_we = 1'b1; ld_addr = 32'h300; ld_data = 32'h3;
        ram_addr = 32'h40; ram_wdata = 32'hA; wreq = 1'b1;
        tick();
        ram_wdata = 32'hB;
        tick();
        wreq = 1'b0;
        #1;
        check("newest_40", ram_rdata, 32'hB);
        ld_we = 1'b0;
        tick();
        #1;
        check("newest_after1", ram_rdata, 32'hB);
        tick();
        #1;
        check("newest_empty", {31'b0, empty}, 32'h1);
        check("newest_arr", ram_rdata, 32'hB);

        // Fill four entries with drain blocked
        ld_we = 1'b1; wreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ram_addr = 32'h100 + 32'(4 * i); ram_wdata = 32'h10000000 + 32'(i);
            tick();
        end
        #1;
        check("fill3_not_full", {31'b0, full}, 32'h0);
        ram_addr = 32'h10C; ram_wdata = 32'h10000003;
        tick();
        wreq = 1'b0;
        #1;
        check("fill_full", {31'b0, full}, 32'h1);
        check("fill_ovf", {31'b0, overflow}, 32'h0);

        // Full: enqueue and drain in the same cycle
        ld_we = 1'b0; ram_addr = 32'h114; ram_wdata = 32'h10000005; wreq = 1'b1;
        tick();
        wreq = 1'b0;
        #1;
        check("sim_full", {31'b0, full}, 32'h1);
        check("sim_ovf", {31'b0, overflow}, 32'h0);
        rd_check("sim_head", 32'h100, 32'h10000000);

        // Full with drain blocked: write is dropped
        ld_we = 1'b1; ram_addr = 32'h110; ram_wdata = 32'h10000004; wreq = 1'b1;
        tick();
        wreq = 1'b0;
        #1;
        check("ovf_set", {31'b0, overflow}, 32'h1);
        check("ovf_full", {31'b0, full}, 32'h1);
        rd_check("ovf_old", 32'h110, 32'hA0000004);
        tick();
        ld_we = 1'b0;
        repeat (4) tick();
        #1;
        check("ovf_drained", {31'b0, empty}, 32'h1);
        rd_check("arr_104", 32'h104, 32'h10000001);
        rd_check("arr_114", 32'h114, 32'h10000005);
        rd_check("arr_110_old", 32'h110, 32'hA0000004);

        // Reset with three pending entries
        ld_we = 1'b1; ld_addr = 32'h300; wreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ram_addr = 32'h200 + 32'(4 * i); ram_wdata = 32'hBBBB0000 + 32'(i);
            tick();
        end
        wreq = 1'b0;
        #1;
        check("pend_not_empty", {31'b0, empty}, 32'h0);
        rd_check("pend_fwd", 32'h204, 32'hBBBB0001);
        rst = 1'b1; ld_addr = 32'h200; ld_data = 32'hDEAD0000;
        #1;
        check("rst_rdata2", ram_rdata, 32'h0);
        tick();
        rst = 1'b0; ld_we = 1'b0;
        #1;
        check("rst_empty2", {31'b0, empty}, 32'h1);
        check("rst_ovf_clr", {31'b0, overflow}, 32'h0);
        rd_check("rst_200", 32'h200, 32'hC0000000);
        repeat (3) tick();
        rd_check("rst_204", 32'h204, 32'hC0000001);
        rd_check("rst_208", 32'h208, 32'hC0000002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/data_ram_wbuf.md
Name: data_ram_wbuf

Overview:
- Data-memory responder for the MEM stage's RAM interface.
- Accepts word address, word write data and write request from the MEM stage; returns the addressed word combinationally on the same cycle. The MEM stage relies on that same-cycle word for byte merges on stores.
- Writes are posted into a small write buffer that drains into a single-write-port word array.
- A loader port (bench/boot image) shares the array write port with priority over the drain.

Parameters:
- ADDR_WIDTH, 32, width of ram_addr_i.
- DATA_WIDTH, 32, word width.
- DEPTH_LOG2, 10, log2 of array depth in words (1024 words).
- WBUF_DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ram_addr_i  in  ADDR_WIDTH  byte address from MEM stage; bits [1:0] ignored; word index = [DEPTH_LOG2+1:2]
- ram_data_i  in  DATA_WIDTH  full merged word to write
- ram_w_request_i  in  1  write request, sampled on clk_i rising edge
- ram_data_o  out  DATA_WIDTH  combinational read word at ram_addr_i
- ld_we_i  in  1  loader write enable
- ld_addr_i  in  ADDR_WIDTH  loader byte address, same indexing
- ld_data_i  in  DATA_WIDTH  loader word
- wbuf_full_o  out  1  write buffer holds WBUF_DEPTH entries (pipeline stall request)
- wbuf_empty_o  out  1  write buffer holds no entries
- overflow_o  out  1  sticky: a write was dropped

Behaviour:
- Reset (rst_i=1 at clock edge):
  - Buffer pointers and count go to 0.
  - wbuf_empty_o=1, wbuf_full_o=0, overflow_o=0.
  - Array contents are not cleared.
  - While rst_i=1: ram_data_o=0, and no enqueue, drain or loader write occurs.
  - Reset mid-drain discards all pending entries.
- Read (combinational, zero latency): ram_data_o is selected in this priority:
  - the newest valid buffer entry whose word index matches;
  - otherwise array[index].
  - Same-cycle incoming ram_data_i is NOT forwarded; it becomes visible the next cycle.
- Enqueue: at a clock edge with ram_w_request_i=1, push {index, ram_data_i} at the tail, if the buffer is not full or a drain occurs in the same cycle.
- Drain:
  - At each clock edge with the buffer non-empty and ld_we_i=0, pop the head and write it to array.
  - At most one array write per cycle.
  - ld_we_i=1 writes ld_data_i to array[ld index] and blocks the drain that cycle.
- Simultaneous enqueue and drain: count unchanged; both pointers advance modulo WBUF_DEPTH.
- Full and write request with no drain (ld_we_i=1): the write is dropped and overflow_o is set to 1 until reset.
- Loader write to an index that also has pending buffer entries:
  - The array is updated, but forwarding still returns the buffer entry.
  - When the buffer entry drains later, it overwrites the loader data.
  - The bench avoids this; it is not an error.
- Duplicate indices in the buffer are legal: they drain in order, and the newest entry wins on read.
- Pointers use log2(WBUF_DEPTH)+1 bits; full and empty are derived from count, registered-free.
- wbuf_full_o and wbuf_empty_o are combinational from count.

Optional Feature:
- Macro: DATA_RAM_RANGE_CHECK_EN.
- When defined:
  - Adds output range_err_o (1 bit, sticky, reset 0).
  - Any access with ram_addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2] != 0 is out of range.
  - An out-of-range write request is not enqueued and sets range_err_o.
  - An out-of-range read returns ram_data_o=0. range_err_o is set only when ram_w_request_i=1 or ld_we_i=1 with an out-of-range address.
  - Out-of-range loader writes are ignored.
- When not defined: upper address bits are ignored (aliasing), and range_err_o does not exist.

Test Plan:
- Post-reset loader preload:
  - Stimulus: ld_we_i writes 0x11223344 to addr 0x10; then read addr 0x10, and addr 0x13.
  - Required: ram_data_o=0x11223344 for both addresses; wbuf_empty_o=1.
- Write then forward:
  - Stimulus: write 0xDEADBEEF to 0x20 at cycle 0.
  - Required: cycle 1 read of 0x20 = 0xDEADBEEF while the entry is in the buffer; after drain it is still 0xDEADBEEF, and wbuf_empty_o=1 by cycle 2.
- Newest-wins:
  - Stimulus: hold ld_we_i=1 (blocking drain); write 0xA to 0x40, then 0xB to 0x40.
  - Required: read 0x40 = 0xB; after ld_we_i drops and two drain cycles, array[0x10] = 0xB.
- Fill and overflow:
  - Stimulus: ld_we_i=1 for 6 cycles while writing 5 distinct words.
  - Required: wbuf_full_o=1 after 4 writes; the 5th write is dropped, overflow_o=1, and that word reads back as old data.
- Simultaneous enqueue and drain when full:
  - Stimulus: buffer full, ld_we_i=0, ram_w_request_i=1.
  - Required: wbuf_full_o stays 1, overflow_o stays 0, and the head entry appears in the array.
- Reset mid-operation:
  - Stimulus: 3 pending entries, then rst_i=1 for one cycle.
  - Required: wbuf_empty_o=1; pending data never reaches the array; a read returns the prior array word.
